eth_phy_10g_rx_ber_descrambler: RTL
===================================

# eth_phy_10g_rx_ber_descrambler

Receive-side 10GBASE-R stage placed directly after the block aligner. It takes aligned 66-bit blocks (2-bit sync header plus 64-bit payload) and the block-lock flag, and does two things:
- descrambles the payload with the self-synchronising x^58+x^39+1 polynomial;
- runs the Clause-49-style high-BER monitor over the sync headers.

It produces the descrambled block stream for the decoder, plus hi_ber and rx_status for link management.

## Interface
- HDR_WIDTH, 2, sync header width
- DATA_WIDTH, 64, payload width
- BER_WINDOW, 19531, window length in clk cycles (125 us at 156.25 MHz); must be ≥ 2
- BER_THRESH, 16, invalid headers per window that assert hi_ber; must be ≥ 1

- clk  in  1  block clock; all logic on its rising edge
- rst  in  1  synchronous, active-low reset
- i_serdes_rx_hdr  in  HDR_WIDTH  aligned sync header
- i_serdes_rx_data  in  DATA_WIDTH  aligned scrambled payload
- i_rx_block_lock  in  1  block lock from the aligner
- o_rx_hdr  out  HDR_WIDTH  sync header, delayed to match o_rx_data
- o_rx_data  out  DATA_WIDTH  descrambled payload
- o_rx_high_ber  out  1  high bit-error-rate flag
- o_rx_status  out  1  link usable: lock and not hi_ber
- o_ber_count  out  8  cumulative invalid-header count, saturating

## Operation
- One block is presented every clk; there is no valid strobe.
- A header is valid iff it equals 2'b01 (control) or 2'b10 (data).

Descrambler:
- Payload is processed bit 0 first: out[i] = in[i] ^ s[38] ^ s[57].
- s is the 58 most recent *scrambled* input bits; s[0] is the newest.
- After each block, s holds the last 58 bits of i_serdes_rx_data.
- Every block is descrambled regardless of header value or lock state.
- s resets to all zeros. Output is self-synchronised from the 2nd block after reset.

BER monitor FSM (states BER_IDLE, BER_COUNT, BER_HIGH):
- **BER_IDLE:** timer = 0, cnt = 0, hi_ber = 0. When i_rx_block_lock = 1, go to BER_COUNT.
- **BER_COUNT / BER_HIGH, per cycle:**
  - Compute new_cnt = cnt + (header invalid).
  - If timer == BER_WINDOW−1 (window end):
    - hi_ber <= (new_cnt ≥ BER_THRESH); go to BER_HIGH if set, else BER_COUNT.
    - cnt <= 0, timer <= 0.
  - Otherwise:
    - timer++; cnt <= min(new_cnt, BER_THRESH).
    - If new_cnt ≥ BER_THRESH: hi_ber <= 1 and go to BER_HIGH immediately (mid-window).
- **Boundary rules:**
  - An invalid header on the window-end cycle counts toward the closing window.
  - hi_ber is cleared only at a window end.
  - i_rx_block_lock = 0 in any state forces BER_IDLE next cycle (timer, cnt, hi_ber cleared); this overrides window-end.
- **o_ber_count:** +1 per invalid header while i_rx_block_lock = 1; saturates at 255. Cleared only by reset.
- **o_rx_status:** registered, equal to i_rx_block_lock & ~hi_ber_next.
- **Arithmetic:**
  - timer width $clog2(BER_WINDOW).
  - cnt width $clog2(BER_THRESH+1).

## Timing
- Reset values (rst = 0 at a clk edge):
  - o_rx_hdr = 0, o_rx_data = 0, o_rx_high_ber = 0, o_rx_status = 0, o_ber_count = 0.
  - FSM in BER_IDLE, s = 0.
- Datapath latency is 1 cycle: the input block at edge N appears on o_rx_hdr/o_rx_data after edge N.
- Status latency is 1 cycle: an input sampled at edge N affects o_rx_high_ber, o_rx_status and o_ber_count after edge N.
- The first window starts on the cycle after lock rises, with timer = 0.
- Reset mid-window discards all window state; no output glitches beyond the reset values.

## Structure
- Shared package eth_phy_10g_pkg holds:
  - SYNC_DATA = 2'b10, SYNC_CTRL = 2'b01;
  - the BER state encoding;
  - descrambler tap constants 38 and 57.
- Sub-module eth_phy_10g_rx_descrambler_lfsr: purely combinational 64-bit unrolled descramble step.
  - Inputs: data, state. Outputs: descrambled data, next state.
  - The top level registers state and outputs.

## Test plan
Bench uses BER_WINDOW = 100, BER_THRESH = 16 unless stated.
- **Descrambler:** feed a 10GBASE-R idle stream scrambled with seed 58'h3FF_FFFF_FFFF_FFFF, lock = 1 → from the 2nd output block onward, o_rx_data = 64'h0000_0000_0000_001E on every block (idle control block) and o_rx_hdr = 2'b01.
- **Threshold:** 15 invalid headers (2'b00) within one window → o_rx_high_ber stays 0. The 16th invalid header at cycle 40 → o_rx_high_ber = 1 one cycle later and o_rx_status = 0. Next window fully valid → o_rx_high_ber = 0 after that window's end edge.
- **Window-end coincidence:** 15 invalid headers early, then the 16th exactly on timer = 99 → hi_ber = 1 at the window-end update. Then 0 invalid headers in the next window → hi_ber clears at the following window end.
- **Lock drop:** with hi_ber = 1, deassert i_rx_block_lock for 1 cycle → next cycle o_rx_high_ber = 0 and o_rx_status = 0. On relock, a new window starts at timer = 0 and o_rx_status = 1 one cycle after relock (all headers valid).
- **Saturation/reset:** 300 invalid headers with lock = 1 → o_ber_count = 255. Assert rst = 0 for 1 cycle mid-stream → all outputs 0 next cycle, o_ber_count = 0.
- **Lock gating:** 20 invalid headers with lock = 0 → o_ber_count stays 0 and o_rx_high_ber stays 0.

Source files
------------

// File: rtl/eth_phy_10g_pkg.sv
// Shared 10GBASE-R receive definitions: sync header codes, BER monitor state
// encoding and the x^58+x^39+1 descrambler tap positions.
package eth_phy_10g_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  // Tap positions into the scrambled-bit history (s[0] is the newest bit)
  localparam int unsigned DESCR_TAP_A   = 38;
  localparam int unsigned DESCR_TAP_B   = 57;
  localparam int unsigned DESCR_STATE_W = 58;

  typedef enum logic [1:0] {
    BER_IDLE  = 2'd0,
    BER_COUNT = 2'd1,
    BER_HIGH  = 2'd2
  } ber_state_e;

  // A sync header is legal only as a data or control marker
  function automatic logic sync_hdr_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_descrambler_lfsr.sv
// Combinational self-synchronising descramble step over one payload word.
// Ports:
//   data         - scrambled payload, bit 0 processed first
//   state        - history of the 58 most recent scrambled bits (bit 0 newest)
//   descr_c      - descrambled payload
//   next_state_c - history after consuming this payload
module eth_phy_10g_rx_descrambler_lfsr
  import eth_phy_10g_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic [DESCR_STATE_W-1:0] state,
  output logic [DATA_WIDTH-1:0]    descr_c,
  output logic [DESCR_STATE_W-1:0] next_state_c
);

  logic [DESCR_STATE_W-1:0] hist;

  // Unrolled bit-serial descrambler; history is fed with the scrambled input bit
  always_comb begin
    descr_c = '0;
    hist    = state;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      descr_c[i] = data[i] ^ hist[DESCR_TAP_A] ^ hist[DESCR_TAP_B];
      hist       = {hist[DESCR_STATE_W-2:0], data[i]};
    end
    next_state_c = hist;
  end

endmodule

// File: rtl/eth_phy_10g_rx_ber_descrambler.sv
// 10GBASE-R receive stage after the block aligner: descrambles each payload and
// runs the high-BER monitor over the sync headers.
// Ports:
//   clk, rst           - block clock, synchronous active-low reset
//   i_serdes_rx_hdr    - aligned sync header
//   i_serdes_rx_data   - aligned scrambled payload
//   i_rx_block_lock    - block lock from the aligner
//   o_rx_hdr/o_rx_data - header and descrambled payload, one cycle latency
//   o_rx_high_ber      - high bit-error-rate flag
//   o_rx_status        - lock and not high BER
//   o_ber_count        - saturating count of invalid headers seen under lock
module eth_phy_10g_rx_ber_descrambler
  import eth_phy_10g_pkg::*;
#(
  parameter int unsigned HDR_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BER_WINDOW = 19531,
  parameter int unsigned BER_THRESH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HDR_WIDTH-1:0]  i_serdes_rx_hdr,
  input  logic [DATA_WIDTH-1:0] i_serdes_rx_data,
  input  logic                  i_rx_block_lock,
  output logic [HDR_WIDTH-1:0]  o_rx_hdr,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_high_ber,
  output logic                  o_rx_status,
  output logic [7:0]            o_ber_count
);

  localparam int unsigned TIMER_W = $clog2(BER_WINDOW);
  localparam int unsigned CNT_W   = $clog2(BER_THRESH + 1);
  // One extra bit so cnt + 1 never wraps before the threshold compare
  localparam int unsigned NCNT_W  = CNT_W + 1;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BER_WINDOW - 1);
  localparam logic [NCNT_W-1:0]  THRESH_N   = NCNT_W'(BER_THRESH);
  localparam logic [CNT_W-1:0]   THRESH_C   = CNT_W'(BER_THRESH);

  // Descrambler datapath
  logic [DESCR_STATE_W-1:0] scr_state;
  logic [DESCR_STATE_W-1:0] scr_state_next;
  logic [DATA_WIDTH-1:0]    descr;

  eth_phy_10g_rx_descrambler_lfsr #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lfsr (
    .data         (i_serdes_rx_data),
    .state        (scr_state),
    .descr_c      (descr),
    .next_state_c (scr_state_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      scr_state <= '0;
      o_rx_hdr  <= '0;
      o_rx_data <= '0;
    end else begin
      scr_state <= scr_state_next;
      o_rx_hdr  <= i_serdes_rx_hdr;
      o_rx_data <= descr;
    end
  end

  // BER monitor
  ber_state_e         ber_state;
  ber_state_e         ber_state_next;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [NCNT_W-1:0]  new_cnt;
  logic               hdr_invalid;
  logic               hi_ber_next;
  logic               status_next;
  logic [7:0]         ber_count_next;

  assign hdr_invalid = ~sync_hdr_valid(2'(i_serdes_rx_hdr));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      ber_state     <= BER_IDLE;
      timer         <= '0;
      cnt           <= '0;
      o_rx_high_ber <= 1'b0;
      o_rx_status   <= 1'b0;
      o_ber_count   <= '0;
    end else begin
      ber_state     <= ber_state_next;
      timer         <= timer_next;
      cnt           <= cnt_next;
      o_rx_high_ber <= hi_ber_next;
      o_rx_status   <= status_next;
      o_ber_count   <= ber_count_next;
    end
  end

  // Next-state logic; loss of lock overrides everything including window end
  always_comb begin
    ber_state_next = ber_state;
    timer_next     = timer;
    cnt_next       = cnt;
    new_cnt        = NCNT_W'(cnt) + NCNT_W'(hdr_invalid);
    if (!i_rx_block_lock) begin
      ber_state_next = BER_IDLE;
      timer_next     = '0;
      cnt_next       = '0;
    end else begin
      case (ber_state)
        BER_IDLE: begin
          ber_state_next = BER_COUNT;
          timer_next     = '0;
          cnt_next       = '0;
        end
        BER_COUNT, BER_HIGH: begin
          if (timer == TIMER_LAST) begin
            // Window end: the verdict of the closing window replaces hi_ber
            ber_state_next = (new_cnt >= THRESH_N) ? BER_HIGH : BER_COUNT;
            timer_next     = '0;
            cnt_next       = '0;
          end else begin
            timer_next = timer + TIMER_W'(1);
            if (new_cnt >= THRESH_N) begin
              ber_state_next = BER_HIGH;
              cnt_next       = THRESH_C;
            end else begin
              cnt_next = CNT_W'(new_cnt);
            end
          end
        end
        default: begin
          ber_state_next = BER_IDLE;
          timer_next     = '0;
          cnt_next       = '0;
        end
      endcase
    end
  end

  // Output logic, registered by the state register process
  always_comb begin
    hi_ber_next    = (ber_state_next == BER_HIGH);
    status_next    = i_rx_block_lock & ~hi_ber_next;
    ber_count_next = o_ber_count;
    if (i_rx_block_lock && hdr_invalid && (o_ber_count != 8'hFF)) begin
      ber_count_next = o_ber_count + 8'd1;
    end
  end

endmodule
